button_debounce: RTL

Conditions a raw, asynchronous push-button input into a clean, glitch-free level for the button edge detector stage. It sits directly upstream of that stage, and its `button_clean` output drives the edge detector's `button` input. It synchronises the pad signal into `clk`, then requires the level to hold for a programmable number of cycles before the output follows. It also counts rejected bounces for bring-up diagnostics.

---
 rtl/button_pkg.sv | 18 +
 rtl/button_sync.sv | 29 ++
 rtl/button_debounce.sv | 122 ++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioning chain.
package button_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } btn_state_t;

    localparam int              GLITCH_W   = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'hFF;

    function automatic logic is_chk_state(input btn_state_t s);
        return (s == S_RISE_CHK) || (s == S_FALL_CHK);
    endfunction

endpackage

// File: rtl/button_sync.sv
// N-flop synchroniser for an asynchronous pad input, with a configurable
// reset level so the chain idles at the pad's inactive value.
module button_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstN,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("button_sync: STAGES must be at least 2 (got %0d)", STAGES);
    end

    logic [STAGES-1:0] sync_sr;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_sr <= {STAGES{RST_VAL}};
        end else begin
            sync_sr <= {sync_sr[STAGES-2:0], d};
        end
    end

    assign q = sync_sr[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronise, qualify a new level for STABLE_CYCLES
// samples, count rejected bounces. Option: BUTTON_DEBOUNCE_ACTIVE_LOW_EN.
module button_debounce
    import button_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                button_raw,
    output logic                button_clean,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("button_debounce: SYNC_STAGES must be 2..4 (got %0d)", SYNC_STAGES);
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("button_debounce: STABLE_CYCLES must be >= 1 (got %0d)", STABLE_CYCLES);
    end

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

`ifdef BUTTON_DEBOUNCE_ACTIVE_LOW_EN
    localparam logic RAW_IDLE = 1'b1;
`else
    localparam logic RAW_IDLE = 1'b0;
`endif

    logic sync_out;
    logic sync_q;

    button_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RAW_IDLE)
    ) u_sync (
        .clk  (clk),
        .rstN (rstN),
        .d    (button_raw),
        .q    (sync_out)
    );

`ifdef BUTTON_DEBOUNCE_ACTIVE_LOW_EN
    assign sync_q = ~sync_out;
`else
    assign sync_q = sync_out;
`endif

    btn_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             clean_d;
    logic             glitch_inc;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        clean_d    = button_clean;
        glitch_inc = 1'b0;
        case (state)
            S_LOW: begin
                if (sync_q) begin
                    state_d = S_RISE_CHK;
                    cnt_d   = '0;
                end
            end
            S_RISE_CHK: begin
                if (!sync_q) begin
                    state_d    = S_LOW;
                    glitch_inc = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_d = S_HIGH;
                    clean_d = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!sync_q) begin
                    state_d = S_FALL_CHK;
                    cnt_d   = '0;
                end
            end
            S_FALL_CHK: begin
                if (sync_q) begin
                    state_d    = S_HIGH;
                    glitch_inc = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_d = S_LOW;
                    clean_d = 1'b0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LOW;
            end
        endcase
    end

    // busy is taken from the next state so it tracks the state register exactly
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= S_LOW;
            cnt          <= '0;
            button_clean <= 1'b0;
            busy         <= 1'b0;
            glitch_cnt   <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            button_clean <= clean_d;
            busy         <= is_chk_state(state_d);
            if (glitch_inc && glitch_cnt != GLITCH_MAX) begin
                glitch_cnt <= glitch_cnt + GLITCH_W'(1);
            end
        end
    end

endmodule
